// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory wait-state controller.
// Contents: FSM state enum, default geometry localparams, address checker.
package dmem_pkg;

    // Default geometry (32-bit words, 64 words); instances derive their own.
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned BE_W       = DATA_W_DEF / 8;
    localparam int unsigned OFF_W      = $clog2(BE_W);
    localparam int unsigned IDX_W      = $clog2(DEPTH_DEF);

    // Widest byte address the checker handles; LATENCY fits in CNT_W bits.
    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns {misaligned, out_of_range} for a zero-extended byte address.
    function automatic logic [1:0] addr_check(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           off_w,
        input int unsigned           idx_w,
        input int unsigned           addr_w
    );
        logic mis;
        logic oor;
        mis = 1'b0;
        oor = 1'b0;
        for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
            if (i < off_w && addr[i]) begin
                mis = 1'b1;
            end
            if (i >= off_w + idx_w && i < addr_w && addr[i]) begin
                oor = 1'b1;
            end
        end
        return {mis, oor};
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl_array.sv
// Single-port DEPTH x DATA_W storage with byte-enabled synchronous write
// and synchronous (registered) read. No reset, so it maps onto one RAM.
// Ports: clk; en (access strobe); we (1=write); be (byte enables);
//        idx (word index); wdata (write data); rdata (read register).
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned BE_N = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write updates only enabled bytes; read register changes only on loads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < BE_N; b++) begin
                    if (be[b]) begin
                        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory block for the MEM stage: single-outstanding valid/ready request
// port, LATENCY wait states, byte-enabled stores, error response for
// misaligned or out-of-range addresses.
// Ports: clk, rst (async, active-high);
//        req_valid/req_ready handshake, req_we, req_be, req_addr, req_wdata;
//        resp_valid (one-cycle pulse), resp_rdata, resp_err (held until the
//        next response); busy (access in flight).
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DATA_W/8-1:0]  req_be,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int unsigned BE_N  = DATA_W / 8;
    localparam int unsigned OFF_N = $clog2(BE_N);
    localparam int unsigned IDX_N = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;

    // Captured request
    logic               q_we;
    logic [BE_N-1:0]    q_be;
    logic [ADDR_W-1:0]  q_addr;
    logic [DATA_W-1:0]  q_wdata;

    // Response qualifier: last completed access was an error-free load
    logic               rd_ok;

    logic               accept_c;
    logic               access_c;
    logic               live_c;
    logic               a_we_c;
    logic [BE_N-1:0]    a_be_c;
    logic [ADDR_W-1:0]  a_addr_c;
    logic [DATA_W-1:0]  a_wdata_c;
    logic [1:0]         a_chk_c;
    logic               a_err_c;
    logic               mem_en_c;
    logic [DATA_W-1:0]  mem_q;

    assign accept_c = req_valid && req_ready;

    // Next-state and wait counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, RESP: begin
                state_nx = IDLE;
                if (accept_c) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = RESP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The array is touched on the edge entering RESP. With no wait states that
    // edge is the accept edge, so the live request is used; from WAIT the
    // captured copy is used.
    assign live_c    = (state != WAIT);
    assign a_we_c    = live_c ? req_we    : q_we;
    assign a_be_c    = live_c ? req_be    : q_be;
    assign a_addr_c  = live_c ? req_addr  : q_addr;
    assign a_wdata_c = live_c ? req_wdata : q_wdata;
    assign a_chk_c   = addr_check(MAX_ADDR_W'(a_addr_c), OFF_N, IDX_N, ADDR_W);
    assign a_err_c   = |a_chk_c;

    // Gated by rst so a request presented during reset can never write
    assign access_c  = (state_nx == RESP) && !rst;
    assign mem_en_c  = access_c && !a_err_c;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (mem_en_c),
        .we    (a_we_c),
        .be    (a_be_c),
        .idx   (a_addr_c[OFF_N +: IDX_N]),
        .wdata (a_wdata_c),
        .rdata (mem_q)
    );

    // State, registered handshake/status outputs, response qualifiers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            req_ready  <= (state_nx != WAIT);
            busy       <= (state_nx != IDLE);
            resp_valid <= (state_nx == RESP);
            if (access_c) begin
                resp_err <= a_err_c;
                rd_ok    <= !a_we_c && !a_err_c;
            end
        end
    end

    // Request capture on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_we    <= 1'b0;
            q_be    <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
        end else if (accept_c) begin
            q_we    <= req_we;
            q_be    <= req_be;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
        end
    end

    // The RAM read register has no reset; a registered qualifier forces zero
    // for stores, errors and after reset, and holds the load data otherwise.
    assign resp_rdata = rd_ok ? mem_q : '0;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: three instances (LATENCY 0, 1, 3) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_wait_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v_valid [3];
    logic        v_ready [3];
    logic        v_we    [3];
    logic [3:0]  v_be    [3];
    logic [31:0] v_addr  [3];
    logic [31:0] v_wdata [3];
    logic        r_valid [3];
    logic [31:0] r_rdata [3];
    logic        r_err   [3];
    logic        v_busy  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_wait_ctrl #(
            .DATA_W  (32),
            .ADDR_W  (32),
            .DEPTH   (64),
            .LATENCY ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (v_valid[g]),
            .req_ready  (v_ready[g]),
            .req_we     (v_we[g]),
            .req_be     (v_be[g]),
            .req_addr   (v_addr[g]),
            .req_wdata  (v_wdata[g]),
            .resp_valid (r_valid[g]),
            .resp_rdata (r_rdata[g]),
            .resp_err   (r_err[g]),
            .busy       (v_busy[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: memory image, pending access, held response values
    logic [31:0] mm     [3][64];
    bit          pend   [3];
    int          acc    [3];
    bit          m_we   [3];
    logic [3:0]  m_be   [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_wd   [3];
    logic [31:0] h_rd   [3];
    bit          h_err  [3];
    bit          m_ready[3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Registers an acceptance for the coming edge from the inputs now applied.
    task automatic model_accept();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                pend[d]  = 1'b0;
                h_rd[d]  = 32'h0;
                h_err[d] = 1'b0;
            end else if (v_valid[d] && m_ready[d]) begin
                pend[d]   = 1'b1;
                acc[d]    = cyc + 1;
                m_we[d]   = v_we[d];
                m_be[d]   = v_be[d];
                m_addr[d] = v_addr[d];
                m_wd[d]   = v_wdata[d];
            end
        end
    endtask

    // Expected outputs for the cycle following edge number cyc.
    task automatic model_check();
        for (int d = 0; d < 3; d++) begin
            int  l;
            bit  wt;
            bit  rs;
            bit  er;
            int  idx;
            l  = lat_of(d);
            wt = pend[d] && cyc >= acc[d] && cyc < acc[d] + l;
            rs = pend[d] && cyc == acc[d] + l;
            if (rs) begin
                er  = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'd256);
                idx = int'(m_addr[d] / 4);
                if (!er && m_we[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_be[d][b]) mm[d][idx][b*8 +: 8] = m_wd[d][b*8 +: 8];
                    end
                end
                h_err[d] = er;
                h_rd[d]  = (er || m_we[d]) ? 32'h0 : mm[d][idx];
            end
            chk($sformatf("d%0d_resp_valid c%0d", d, cyc), 32'(r_valid[d]), 32'(rs));
            chk($sformatf("d%0d_req_ready c%0d", d, cyc), 32'(v_ready[d]), 32'(!wt));
            chk($sformatf("d%0d_busy c%0d", d, cyc), 32'(v_busy[d]), 32'(pend[d] && cyc >= acc[d]));
            chk($sformatf("d%0d_resp_err c%0d", d, cyc), 32'(r_err[d]), 32'(h_err[d]));
            chk($sformatf("d%0d_resp_rdata c%0d", d, cyc), r_rdata[d], h_rd[d]);
            m_ready[d] = !wt;
            if (rs) pend[d] = 1'b0;
        end
    endtask

    task automatic tick();
        model_accept();
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    // One access on instance d; returns response and timing observations.
    task automatic do_req(input int d, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit e,
                          output int n, output int nlow, output int nbusy);
        int guard;
        guard      = 0;
        v_valid[d] = 1'b1;
        v_we[d]    = w;
        v_be[d]    = b;
        v_addr[d]  = a;
        v_wdata[d] = wd;
        while (!v_ready[d] && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        v_valid[d] = 1'b0;
        v_addr[d]  = $urandom;
        v_wdata[d] = $urandom;
        n = 1; nlow = 0; nbusy = 0;
        while (!r_valid[d] && n < 40) begin
            if (!v_ready[d]) nlow++;
            if (v_busy[d]) nbusy++;
            tick();
            n++;
        end
        if (v_busy[d]) nbusy++;
        rd = r_rdata[d];
        e  = r_err[d];
        checks++;
        if (!r_valid[d]) begin
            errors++;
            $display("FAIL d%0d_resp_timeout actual=no_response required=resp_valid", d);
        end
    endtask

    logic [31:0] rd;
    bit          e;
    int          n, nlow, nbusy;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            v_valid[d] = 1'b0; v_we[d] = 1'b0; v_be[d] = 4'h0;
            v_addr[d] = 32'h0; v_wdata[d] = 32'h0;
            pend[d] = 1'b0; acc[d] = 0; h_rd[d] = 32'h0; h_err[d] = 1'b0; m_ready[d] = 1'b1;
        end
        repeat (3) tick();
        chk("rst_ready", 32'(v_ready[0]), 32'h1);
        chk("rst_busy", 32'(v_busy[2]), 32'h0);
        chk("rst_rdata", r_rdata[1], 32'h0);
        rst = 1'b0;
        tick();

        // Define every word of every instance
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) begin
                do_req(d, 1'b1, 4'hF, 32'(i * 4), $urandom, rd, e, n, nlow, nbusy);
            end
        end

        // No wait states: store then load at 0x0
        do_req(0, 1'b1, 4'hF, 32'h0, 32'h0000000A, rd, e, n, nlow, nbusy);
        chk("l0_store_lat", 32'(n), 32'd1);
        chk("l0_store_rdata", rd, 32'h0);
        do_req(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, e, n, nlow, nbusy);
        chk("l0_load_lat", 32'(n), 32'd1);
        chk("l0_load_rdata", rd, 32'h0000000A);
        chk("l0_load_err", 32'(e), 32'h0);

        // Three wait states: load 0x4 preset to 20
        do_req(2, 1'b1, 4'hF, 32'h4, 32'd20, rd, e, n, nlow, nbusy);
        do_req(2, 1'b0, 4'h0, 32'h4, 32'h0, rd, e, n, nlow, nbusy);
        chk("l3_load_rdata", rd, 32'd20);
        chk("l3_load_lat", 32'(n), 32'd4);
        chk("l3_ready_low", 32'(nlow), 32'd3);
        chk("l3_busy_cycles", 32'(nbusy), 32'd4);

        // Byte enables
        do_req(0, 1'b1, 4'hF, 32'h8, 32'hAABBCCDD, rd, e, n, nlow, nbusy);
        do_req(0, 1'b1, 4'b0101, 32'h8, 32'h11223344, rd, e, n, nlow, nbusy);
        do_req(0, 1'b1, 4'b0000, 32'h8, 32'hFFFFFFFF, rd, e, n, nlow, nbusy);
        chk("be0_err", 32'(e), 32'h0);
        do_req(0, 1'b0, 4'h0, 32'h8, 32'h0, rd, e, n, nlow, nbusy);
        chk("be_merge", rd, 32'hAA22CC44);

        // Errors: misaligned store leaves memory alone, out-of-range load
        do_req(1, 1'b1, 4'hF, 32'h4, 32'h55, rd, e, n, nlow, nbusy);
        do_req(1, 1'b1, 4'hF, 32'h6, 32'hDEADBEEF, rd, e, n, nlow, nbusy);
        chk("mis_store_err", 32'(e), 32'h1);
        chk("mis_store_lat", 32'(n), 32'd2);
        do_req(1, 1'b0, 4'h0, 32'h4, 32'h0, rd, e, n, nlow, nbusy);
        chk("mis_store_nochange", rd, 32'h55);
        do_req(1, 1'b0, 4'h0, 32'h100, 32'h0, rd, e, n, nlow, nbusy);
        chk("oor_load_err", 32'(e), 32'h1);
        chk("oor_load_rdata", rd, 32'h0);

        // Back-to-back loads held valid on the LATENCY=1 instance
        begin
            int k, nresp, first, last, guard;
            bit acc_now;
            k = 0; nresp = 0; first = -1; last = 0; guard = 0;
            v_valid[1] = 1'b1; v_we[1] = 1'b0; v_addr[1] = 32'd80;
            while (nresp < 8 && guard < 100) begin
                acc_now = v_valid[1] && v_ready[1];
                tick();
                guard++;
                if (acc_now) begin
                    if (first < 0) first = cyc;
                    k++;
                    if (k < 8) v_addr[1] = 32'(80 + k * 4);
                    else v_valid[1] = 1'b0;
                end
                if (r_valid[1]) begin
                    nresp++;
                    last = cyc;
                end
            end
            v_valid[1] = 1'b0;
            chk("b2b_count", 32'(nresp), 32'd8);
            chk("b2b_span", 32'(last - first), 32'd15);
        end

        // Reset while a store sits in WAIT
        do_req(2, 1'b1, 4'hF, 32'hC, 32'h00001234, rd, e, n, nlow, nbusy);
        v_valid[2] = 1'b1; v_we[2] = 1'b1; v_be[2] = 4'hF;
        v_addr[2] = 32'hC; v_wdata[2] = 32'h0000DEAD;
        tick();
        v_valid[2] = 1'b0;
        tick();
        chk("rst_mid_busy_before", 32'(v_busy[2]), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", 32'(v_ready[2]), 32'h1);
        chk("rst_mid_busy", 32'(v_busy[2]), 32'h0);
        chk("rst_mid_valid", 32'(r_valid[2]), 32'h0);
        chk("rst_mid_rdata", r_rdata[2], 32'h0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        do_req(2, 1'b0, 4'h0, 32'hC, 32'h0, rd, e, n, nlow, nbusy);
        chk("rst_mid_old_value", rd, 32'h00001234);

        // Randomised traffic across all instances
        for (int t = 0; t < 300; t++) begin
            int d;
            int kind;
            logic [31:0] a;
            d    = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 7));
            a    = 32'($urandom_range(0, 63) * 4);
            if (kind == 6) a = a | 32'($urandom_range(1, 3));
            if (kind == 7) a = a + 32'($urandom_range(1, 1000) * 256);
            do_req(d, 1'($urandom), 4'($urandom), a, $urandom, rd, e, n, nlow, nbusy);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
